// File: rtl/operation_encoder_if.sv
// Player button / game-state inputs and encoded motion outputs
// between the board pins and the physics engine.
interface operation_encoder_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_boost;
    logic [2:0] state;
    logic [2:0] operation_code;
    logic       boost;
    logic [7:0] boost_energy;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_boost, state,
        input  operation_code, boost, boost_energy
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_boost, state,
        output operation_code, boost, boost_energy
    );
endinterface

// File: rtl/operation_encoder.sv
// Per-player button encoder: sync, debounce, last-pressed-wins
// direction arbitration and boost energy/cooldown FSM.
module operation_encoder #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TICK_DIV        = 1000000,
    parameter int ENERGY_MAX      = 200,
    parameter int COOLDOWN_TICKS  = 100
) (
    input logic clk,
    input logic rst,
    operation_encoder_if.slave bus
);
    localparam logic [2:0]  ST_RACING = 3'd4;
    localparam logic [2:0]  ST_PAUSE  = 3'd5;
    localparam logic [2:0]  OP_NIL    = 3'd0;
    localparam logic [2:0]  OP_UP     = 3'd1;
    localparam logic [2:0]  OP_DOWN   = 3'd2;
    localparam logic [2:0]  OP_LEFT   = 3'd3;
    localparam logic [2:0]  OP_RIGHT  = 3'd4;
    localparam logic [17:0] DB_LAST   = 18'(DEBOUNCE_CYCLES - 1);
    localparam logic [19:0] TK_LAST   = 20'(TICK_DIV - 1);
    localparam logic [7:0]  E_MAX     = 8'(ENERGY_MAX);
    localparam logic [7:0]  CD_LOAD   = 8'(COOLDOWN_TICKS);

    typedef enum logic [1:0] {
        B_READY,
        B_ACTIVE,
        B_COOLDOWN
    } bst_e;

    // bit order: 0 up, 1 down, 2 left, 3 right, 4 boost
    logic [4:0]       raw;
    logic [4:0]       sync1_q, sync2_q;
    logic [4:0]       deb_q, deb_d;
    logic [4:0][17:0] dcnt_q, dcnt_d;
    logic [2:0]       cur_q, cur_d;
    logic [3:0]       rise, held;
    logic             cur_held;
    logic [19:0]      tcnt_q, tcnt_d;
    logic             racing, paused, tick;
    bst_e             bst_q, bst_d;
    logic [7:0]       energy_q, energy_d;
    logic [7:0]       cool_q, cool_d;
    logic [7:0]       e_dec, c_dec;
    logic [2:0]       op_q;
    logic             boost_q;

    assign raw = {bus.btn_boost, bus.btn_right, bus.btn_left,
                  bus.btn_down, bus.btn_up};

    assign racing = (bus.state == ST_RACING);
    assign paused = (bus.state == ST_PAUSE);
    assign tick   = racing && (tcnt_q == TK_LAST);

    function automatic logic [2:0] first_dir(input logic [3:0] v);
        if (v[0])      first_dir = OP_UP;
        else if (v[1]) first_dir = OP_DOWN;
        else if (v[2]) first_dir = OP_LEFT;
        else if (v[3]) first_dir = OP_RIGHT;
        else           first_dir = OP_NIL;
    endfunction

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 5; i++) begin
            dcnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DB_LAST) deb_d[i] = sync2_q[i];
                else dcnt_d[i] = dcnt_q[i] + 18'd1;
            end
        end
    end

    // arbitration looks at the level being registered this edge
    assign held = deb_d[3:0];
    assign rise = deb_d[3:0] & ~deb_q[3:0];

    always_comb begin
        cur_d = cur_q;
        unique case (cur_q)
            OP_UP:    cur_held = held[0];
            OP_DOWN:  cur_held = held[1];
            OP_LEFT:  cur_held = held[2];
            OP_RIGHT: cur_held = held[3];
            default:  cur_held = 1'b0;
        endcase
        if (|rise) cur_d = first_dir(rise);
        else if (cur_q != OP_NIL && !cur_held) cur_d = first_dir(held);
    end

    always_comb begin
        tcnt_d = '0;
        if (racing) tcnt_d = (tcnt_q == TK_LAST) ? '0 : tcnt_q + 20'd1;
        else if (paused) tcnt_d = tcnt_q;
    end

    always_comb begin
        bst_d    = bst_q;
        energy_d = energy_q;
        cool_d   = cool_q;
        e_dec    = energy_q;
        c_dec    = cool_q;
        if (!racing && !paused) begin
            bst_d    = B_READY;
            energy_d = E_MAX;
            cool_d   = '0;
        end else if (racing) begin
            unique case (bst_q)
                B_READY: begin
                    if (deb_q[4] && cur_q != OP_NIL && energy_q != 8'd0)
                        bst_d = B_ACTIVE;
                    else if (tick && energy_q < E_MAX)
                        energy_d = energy_q + 8'd1;
                end
                B_ACTIVE: begin
                    if (tick && energy_q != 8'd0) e_dec = energy_q - 8'd1;
                    energy_d = e_dec;
                    if (!deb_q[4] || cur_q == OP_NIL || e_dec == 8'd0) begin
                        bst_d  = B_COOLDOWN;
                        cool_d = CD_LOAD;
                    end
                end
                B_COOLDOWN: begin
                    if (tick && cool_q != 8'd0) c_dec = cool_q - 8'd1;
                    cool_d = c_dec;
                    if (c_dec == 8'd0) bst_d = B_READY;
                end
                default: bst_d = B_READY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            dcnt_q   <= '0;
            cur_q    <= OP_NIL;
            tcnt_q   <= '0;
            bst_q    <= B_READY;
            energy_q <= E_MAX;
            cool_q   <= '0;
            op_q     <= OP_NIL;
            boost_q  <= 1'b0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            dcnt_q   <= dcnt_d;
            cur_q    <= cur_d;
            tcnt_q   <= tcnt_d;
            bst_q    <= bst_d;
            energy_q <= energy_d;
            cool_q   <= cool_d;
            op_q     <= racing ? cur_q : OP_NIL;
            boost_q  <= racing && (bst_d == B_ACTIVE);
        end
    end

    assign bus.operation_code = op_q;
    assign bus.boost          = boost_q;
    assign bus.boost_energy   = energy_q;
endmodule

// File: tb/tb_operation_encoder.sv
// Directed plus randomized bench for operation_encoder against
// a cycle-level behavioural reference model.
module tb_operation_encoder;
    localparam int DC = 4;
    localparam int TD = 2;
    localparam int EM = 8;
    localparam int CT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn = '0;
    logic [2:0] st  = 3'd4;
    int         vectors = 0;
    int         miscompares = 0;
    int         edge_n = 0;

    operation_encoder_if ifc ();

    operation_encoder #(
        .DEBOUNCE_CYCLES(DC),
        .TICK_DIV(TD),
        .ENERGY_MAX(EM),
        .COOLDOWN_TICKS(CT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    // reference model state: plain integers, run-length debounce
    int m_s1[5], m_s2[5], m_deb[5], m_run[5];
    int m_cur, m_mode, m_energy, m_cool, m_tc, m_op, m_boost;
    localparam int M_READY = 0, M_ACT = 1, M_CD = 2;

    task automatic model_step();
        int nd[5];
        int ncur;
        int racing, tick;
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_run[i] = 0;
            end
            m_cur = 0; m_mode = M_READY; m_energy = EM; m_cool = 0;
            m_tc = 0; m_op = 0; m_boost = 0;
            return;
        end
        for (int i = 0; i < 5; i++) begin
            nd[i] = m_deb[i];
            if (m_s2[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DC) begin
                    nd[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end else m_run[i] = 0;
            m_s2[i] = m_s1[i];
            m_s1[i] = int'(btn[i]);
        end
        ncur = -1;
        for (int j = 0; j < 4; j++)
            if (ncur < 0 && nd[j] == 1 && m_deb[j] == 0) ncur = j + 1;
        if (ncur < 0) begin
            ncur = m_cur;
            if (m_cur != 0 && nd[m_cur-1] == 0) begin
                ncur = 0;
                for (int j = 3; j >= 0; j--) if (nd[j] == 1) ncur = j + 1;
            end
        end
        racing = (st == 3'd4);
        tick = racing && (m_tc == TD - 1);
        if (racing) begin
            case (m_mode)
                M_READY:
                    if (m_deb[4] == 1 && m_cur != 0 && m_energy > 0)
                        m_mode = M_ACT;
                    else if (tick && m_energy < EM) m_energy++;
                M_ACT: begin
                    if (tick && m_energy > 0) m_energy--;
                    if (m_deb[4] == 0 || m_cur == 0 || m_energy == 0) begin
                        m_mode = M_CD;
                        m_cool = CT;
                    end
                end
                default: begin
                    if (tick) m_cool--;
                    if (m_cool <= 0) begin
                        m_mode = M_READY;
                        m_cool = 0;
                    end
                end
            endcase
            m_tc = (m_tc + 1) % TD;
        end else if (st != 3'd5) begin
            m_mode = M_READY; m_energy = EM; m_cool = 0; m_tc = 0;
        end
        m_op = racing ? m_cur : 0;
        m_boost = (racing && m_mode == M_ACT) ? 1 : 0;
        for (int i = 0; i < 5; i++) m_deb[i] = nd[i];
        m_cur = ncur;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [4:0] b, input logic [2:0] s);
        btn = b;
        st  = s;
        ifc.btn_up    = b[0];
        ifc.btn_down  = b[1];
        ifc.btn_left  = b[2];
        ifc.btn_right = b[3];
        ifc.btn_boost = b[4];
        ifc.state     = s;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        edge_n++;
        check("model_op", 32'(ifc.operation_code), 32'(m_op));
        check("model_boost", 32'(ifc.boost), 32'(m_boost));
        check("model_energy", 32'(ifc.boost_energy), 32'(m_energy));
    endtask

    task automatic wait_boost(input logic lvl, input int budget,
                              input string tag);
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (ifc.boost === lvl) break;
        end
        check(tag, 32'(ifc.boost), 32'(lvl));
    endtask

    localparam logic [4:0] B_UP = 5'b00001, B_DN = 5'b00010;
    localparam logic [4:0] B_LF = 5'b00100, B_RT = 5'b01000;
    localparam logic [4:0] B_BST = 5'b10000;

    initial begin
        logic [2:0] others [6];
        others = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
        apply('0, 3'd4);
        rst = 1'b1;
        cyc();
        check("rst_op", 32'(ifc.operation_code), 0);
        check("rst_boost", 32'(ifc.boost), 0);
        check("rst_energy", 32'(ifc.boost_energy), EM);
        cyc();
        rst = 1'b0;
        while (edge_n < 10) cyc();
        apply(B_UP, 3'd4);
        while (edge_n < 16) begin
            cyc();
            check("lat_early", 32'(ifc.operation_code), 0);
        end
        cyc();
        check("lat_edge17", 32'(ifc.operation_code), 1);

        apply('0, 3'd4);
        repeat (10) cyc();
        check("release_nil", 32'(ifc.operation_code), 0);
        apply(B_UP, 3'd4);
        repeat (3) cyc();
        apply('0, 3'd4);
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("glitch", 32'(ifc.operation_code), 0);
        end

        apply(B_UP, 3'd4);
        repeat (8) cyc();
        check("hold_up", 32'(ifc.operation_code), 1);
        apply(B_UP | B_RT, 3'd4);
        repeat (8) cyc();
        check("last_right", 32'(ifc.operation_code), 4);
        apply(B_UP, 3'd4);
        repeat (8) cyc();
        check("fallback_up", 32'(ifc.operation_code), 1);
        apply('0, 3'd4);
        repeat (8) cyc();
        apply(B_DN | B_LF, 3'd4);
        repeat (8) cyc();
        check("prio_down", 32'(ifc.operation_code), 2);
        apply('0, 3'd4);
        repeat (8) cyc();
        check("all_released", 32'(ifc.operation_code), 0);

        apply(B_RT | B_BST, 3'd4);
        wait_boost(1'b1, 20, "boost_on");
        wait_boost(1'b0, 30, "boost_drained");
        check("drained_energy", 32'(ifc.boost_energy), 0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("cooldown_boost", 32'(ifc.boost), 0);
            check("cooldown_energy", 32'(ifc.boost_energy), 0);
        end
        wait_boost(1'b1, 12, "rearm_boost");
        check("rearm_energy", 32'(ifc.boost_energy), 1);

        apply(B_RT, 3'd1);
        repeat (10) cyc();
        apply(B_RT | B_BST, 3'd4);
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (ifc.boost === 1'b1 && ifc.boost_energy === 8'd5) break;
        end
        check("reach_e5", 32'(ifc.boost_energy), 5);
        apply(B_RT | B_BST, 3'd5);
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("pause_boost", 32'(ifc.boost), 0);
            check("pause_op", 32'(ifc.operation_code), 0);
            check("pause_energy", 32'(ifc.boost_energy), 5);
        end
        apply(B_RT | B_BST, 3'd4);
        cyc();
        check("resume_boost", 32'(ifc.boost), 1);
        check("resume_energy", 32'(ifc.boost_energy), 5);
        check("resume_op", 32'(ifc.operation_code), 4);

        apply('0, 3'd1);
        repeat (10) cyc();
        apply(B_UP | B_BST, 3'd3);
        repeat (10) cyc();
        check("gate_op", 32'(ifc.operation_code), 0);
        check("gate_boost", 32'(ifc.boost), 0);
        check("gate_energy", 32'(ifc.boost_energy), EM);
        apply(B_UP | B_BST, 3'd4);
        wait_boost(1'b1, 10, "gate_go");
        apply(B_UP, 3'd4);
        wait_boost(1'b0, 12, "cd_enter");
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midcd_rst_op", 32'(ifc.operation_code), 0);
        check("midcd_rst_boost", 32'(ifc.boost), 0);
        check("midcd_rst_energy", 32'(ifc.boost_energy), EM);

        for (int n = 0; n < 400; n++) begin
            int r;
            logic [2:0] s;
            r = int'($urandom_range(0, 19));
            if (r < 14) s = 3'd4;
            else if (r < 17) s = 3'd5;
            else s = others[$urandom_range(0, 5)];
            apply(5'($urandom), s);
            rst = ($urandom_range(0, 99) == 0);
            repeat ($urandom_range(1, 12)) begin
                cyc();
                rst = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/operation_encoder.md
Name: operation_encoder

Overview:
- Converts five raw player buttons (up/down/left/right/boost) into the 3-bit `operation_code` and 1-bit `boost` consumed by the physics engine.
- Performs synchronisation, debouncing, last-pressed-wins direction arbitration and a boost energy/cooldown state machine.
- One instance per player; sits between the board button pins and the physics engine, and is gated by the game `state` from the state encoder.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles before a button's debounced level changes (counter width 18 bits; values 1..262143).
- TICK_DIV, 1000000, clk cycles per boost tick (counter width 20 bits; values 1..1048575).
- ENERGY_MAX, 200, full boost energy (1..255).
- COOLDOWN_TICKS, 100, ticks spent in cooldown after a boost ends (1..255).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- btn_up  input  1  raw asynchronous button
- btn_down  input  1  raw asynchronous button
- btn_left  input  1  raw asynchronous button
- btn_right  input  1  raw asynchronous button
- btn_boost  input  1  raw asynchronous button
- state  input  3  game state: IDLE=0, SETTING=1, COUNTDOWN=3, RACING=4, PAUSE=5, FINISH=6
- operation_code  output  3  NIL=0, UP=1, DOWN=2, LEFT=3, RIGHT=4 (registered)
- boost  output  1  boost active (registered)
- boost_energy  output  8  current energy level (registered)

Behaviour:
- Reset: all synchronisers, debounced levels and counters = 0; current direction = NIL; boost FSM = B_READY.
  - operation_code = 0, boost = 0, boost_energy = ENERGY_MAX, tick counter = 0, cooldown counter = 0.
  - rst asserted mid-boost or mid-cooldown returns to these values on the next edge.
- Synchroniser: each button passes through a 2-flop synchroniser.
- Debounce: per-button counter.
  - Synchronised level == debounced level: counter cleared.
  - Otherwise counter increments; on reaching DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
  - Any glitch back to the old level before then clears the counter with no change.
- Latency: a raw level held from edge k appears on the debounced level at edge k+2+DEBOUNCE_CYCLES. operation_code and boost reflect it one edge later (total DEBOUNCE_CYCLES+3).
- Direction arbitration: runs in every state, on debounced levels.
  - A debounced rising edge on a direction makes that direction current.
  - Simultaneous rising edges: priority UP > DOWN > LEFT > RIGHT.
  - Current direction released: fall back to the highest-priority still-held direction (same order); none held -> NIL.
  - A rising edge in the same cycle as the current direction's release: the rising edge wins.
- operation_code <= current direction when state == RACING, else NIL.
- Tick counter: counts 0..TICK_DIV-1 and wraps; tick is asserted in the cycle the count equals TICK_DIV-1.
  - state == RACING: counter advances.
  - state == PAUSE: counter held.
  - Any other state: counter cleared.
- Boost FSM: advances only when state == RACING.
  - state == PAUSE: FSM state, energy and cooldown counter all frozen; boost output = 0.
  - Any other state (IDLE, SETTING, COUNTDOWN, FINISH or undefined): force B_READY, energy = ENERGY_MAX, cooldown counter = 0, boost = 0.
- B_READY:
  - Debounced boost held, current direction != NIL and energy > 0 -> B_ACTIVE on the next edge.
  - Otherwise, on tick with energy < ENERGY_MAX, energy increments by 1 (saturates at ENERGY_MAX).
- B_ACTIVE: boost = 1.
  - On tick, energy decrements by 1.
  - Exit to B_COOLDOWN (cooldown counter loaded with COOLDOWN_TICKS) when any of these holds: boost button released, current direction == NIL, or energy reaches 0 (including via a decrement this cycle).
  - The exit is evaluated on the registered energy value after decrement, so energy never underflows below 0.
- B_COOLDOWN: boost = 0 and no recharge.
  - On tick, cooldown counter decrements.
  - Counter reaching 0 -> B_READY.
  - Holding boost in cooldown does not re-arm; re-entry requires the B_READY conditions to hold after return.
- boost output <= (FSM == B_ACTIVE) && state == RACING, registered in the same cycle as the FSM update.
- boost_energy reflects the registered energy every cycle.

Test Plan:
- Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, TICK_DIV=2, ENERGY_MAX=8, COOLDOWN_TICKS=3.
- Debounce/latency: state=4; btn_up high from edge 10 -> operation_code=1 at edge 17, not before. A 3-cycle btn_up pulse -> operation_code stays 0.
- Last-pressed wins: hold UP, then add RIGHT -> code 4; release RIGHT -> code 1; press DOWN and LEFT on the same cycle from NIL -> code 2; release all -> 0.
- Boost drain: state=4, hold RIGHT+boost -> boost=1. Energy falls 8->0 over 16 cycles, then boost=0 and FSM enters cooldown for 3 ticks (6 cycles). With boost still held, boost stays 0 until energy > 0 after recharge.
- Pause freeze: mid-boost with energy=5, state=5 for 20 cycles -> boost=0, operation_code=0, energy stays 5. Return to state=4 with buttons held -> boost=1 and energy resumes from 5.
- State gating/reset: in state=3 hold UP+boost -> operation_code=0, boost=0, energy=8. Assert rst for 1 cycle mid-cooldown -> all outputs reset; energy=8 on the next edge.
